gol_gen_ctrl: RTL
=================

// Module: gol_gen_ctrl
// PURPOSE
//  Generation controller for the toroidal Game-of-Life cell array. Accepts host commands to
//  load a pattern row by row, run, single-step or pause the array. Paces generations, counts
//  them, and halts automatically on extinction, still life or a generation limit.
//  Sits between the host command interface and the cell array's load/step inputs.
// PARAMETERS
//  WIDTH     10   cells per row
//  HEIGHT    10   rows; localparam ROW_W = $clog2(HEIGHT)
//  GEN_W     16   generation counter width
//  STEP_DIV  1    clk cycles between generation steps in RUN (>=1)
// PORTS
//  clk             in   1              clock
//  rst             in   1              reset, asynchronous, active-low
//  cmd_valid       in   1              command present
//  cmd_ready       out  1              command accepted when valid&ready
//  cmd_op          in   3              gol_pkg::op_e
//  cmd_row         in   ROW_W          row index for OP_WRITE_ROW
//  cmd_data        in   WIDTH          row bits for OP_WRITE_ROW; bit c = column c
//  gen_limit       in   GEN_W          halt after this many generations; 0 = unlimited
//  grid_state      in   WIDTH*HEIGHT   current cells; index = row*WIDTH+col
//  grid_next       in   WIDTH*HEIGHT   combinational next-generation cells from array
//  grid_load       out  1              1-cycle pulse: array loads grid_load_data
//  grid_load_data  out  WIDTH*HEIGHT   shadow pattern
//  grid_step       out  1              1-cycle pulse: array advances one generation
//  busy            out  1              state is RUN or SETTLE
//  gen_count       out  GEN_W          generations since last commit; saturates at all-ones
//  halt_valid      out  1              1-cycle pulse on automatic halt
//  halt_reason     out  2              gol_pkg::halt_e; held until next RUN/STEP/COMMIT
//  cmd_err         out  1              1-cycle pulse: accepted op ignored (illegal or in RUN)
// BEHAVIOUR
//  Reset: state IDLE; shadow = 0; all outputs 0; halt_reason = H_NONE; cmd_ready = 0.
//  States: IDLE, RUN, SETTLE, HALT. cmd_ready = 1 in IDLE, RUN and HALT; 0 in SETTLE.
//  Ops in IDLE/HALT:
//   WRITE_ROW: shadow[row] <= data. cmd_row >= HEIGHT -> no write, cmd_err.
//   CLEAR: shadow <= 0.
//   COMMIT: grid_load pulse next cycle; gen_count <= 0; halt_reason <= H_NONE; -> IDLE.
//   RUN: -> RUN, pace counter <= 0.
//   STEP: one halt check; if clear, grid_step pulse, gen_count++, -> SETTLE, then IDLE.
//   PAUSE/NOP: no effect.
//  Ops in RUN: PAUSE -> IDLE next cycle; any other op accepted and dropped with cmd_err.
//  Halt check, evaluated in RUN on a pace tick (every STEP_DIV cycles) and on STEP.
//  Priority: grid_state==0 -> H_EXTINCT; else grid_next==grid_state -> H_STILL;
//  else gen_limit!=0 && gen_count>=gen_limit -> H_LIMIT.
//  Any hit: -> HALT, halt_valid pulse, no grid_step.
//  On no hit: grid_step pulse, gen_count++ (saturating), -> SETTLE.
//  SETTLE lasts 1 cycle so the array output settles, then returns to RUN or IDLE.
//  PAUSE accepted in the same cycle a halt check hits: the halt wins, giving HALT with a
//  halt_valid pulse.
//  grid_load and grid_step are never asserted in the same cycle.
//  Latency: cmd accept -> grid_step/grid_load pulse on the next cycle (registered outputs).
//  Reset mid-RUN: immediate return to reset values; no grid_step glitch.
// STRUCTURE
//  gol_pkg: op_e {OP_NOP, OP_WRITE_ROW, OP_CLEAR, OP_COMMIT, OP_RUN, OP_STEP, OP_PAUSE};
//   halt_e {H_NONE, H_EXTINCT, H_STILL, H_LIMIT}; state_e.
//  Sub-module gol_shadow_buf: row-addressed WIDTH x HEIGHT register with clear, flat output.
// TESTING
//  1 Write a glider in rows 1-3, COMMIT -> one grid_load cycle, data matches, gen_count = 0.
//  2 Blinker, gen_limit = 5, RUN -> exactly 5 grid_step pulses, then HALT with H_LIMIT.
//  3 2x2 block, RUN -> no grid_step, halt_valid with H_STILL; gen_count stays 0.
//  4 Lone cell, STEP -> 1 grid_step, IDLE; then RUN -> H_EXTINCT.
//  5 STEP_DIV = 4, RUN then PAUSE at cycle 10 -> steps at 0, 5, 10 spacing, then IDLE.
//     Also WRITE_ROW during RUN -> cmd_err.
//  6 Drop rst mid-RUN while grid_step is high -> all outputs 0 in the same cycle.
//     After release: IDLE, shadow = 0.

Source files
------------

// File: rtl/gol_pkg.sv
// Shared types for the Game-of-Life generation controller: host opcodes,
// automatic-halt reasons and controller states.
package gol_pkg;

   typedef enum logic [2:0] {
      OP_NOP       = 3'd0,
      OP_WRITE_ROW = 3'd1,
      OP_CLEAR     = 3'd2,
      OP_COMMIT    = 3'd3,
      OP_RUN       = 3'd4,
      OP_STEP      = 3'd5,
      OP_PAUSE     = 3'd6
   } op_e;

   typedef enum logic [1:0] {
      H_NONE    = 2'd0,
      H_EXTINCT = 2'd1,
      H_STILL   = 2'd2,
      H_LIMIT   = 2'd3
   } halt_e;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_SETTLE = 2'd2,
      S_HALT   = 2'd3
   } state_e;

endpackage

// File: rtl/gol_shadow_buf.sv
// Row-addressed shadow pattern store. Holds the pattern the host builds up
// row by row before committing it to the cell array. Flat output uses
// index row*WIDTH+col. Clear has priority over a row write.
module gol_shadow_buf #(
   parameter int WIDTH  = 10,
   parameter int HEIGHT = 10,
   parameter int ROW_W  = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clr,
   input  logic                      wr_en,
   input  logic [ROW_W-1:0]          wr_row,
   input  logic [WIDTH-1:0]          wr_data,
   output logic [WIDTH*HEIGHT-1:0]   data
);

   logic [WIDTH*HEIGHT-1:0] data_r;

   // Pattern storage: clear wipes every row, a write replaces one row
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_r <= {(WIDTH*HEIGHT){1'b0}};
      end else if (clr) begin
         data_r <= {(WIDTH*HEIGHT){1'b0}};
      end else begin
         for (int r = 0; r < HEIGHT; r++) begin
            if (wr_en && (wr_row == ROW_W'(r))) begin
               data_r[r*WIDTH +: WIDTH] <= wr_data;
            end
         end
      end
   end

   assign data = data_r;

endmodule

// File: rtl/gol_gen_ctrl.sv
// Generation controller for the toroidal Game-of-Life array. Takes host
// commands, loads the shadow pattern into the array, paces generation
// steps in RUN, counts generations and halts on extinction, still life or
// a generation limit. All outputs are registered.
module gol_gen_ctrl
   import gol_pkg::*;
#(
   parameter int WIDTH    = 10,
   parameter int HEIGHT   = 10,
   parameter int GEN_W    = 16,
   parameter int STEP_DIV = 1,
   localparam int ROW_W   = $clog2(HEIGHT)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [2:0]                cmd_op,
   input  logic [ROW_W-1:0]          cmd_row,
   input  logic [WIDTH-1:0]          cmd_data,
   input  logic [GEN_W-1:0]          gen_limit,
   input  logic [WIDTH*HEIGHT-1:0]   grid_state,
   input  logic [WIDTH*HEIGHT-1:0]   grid_next,
   output logic                      grid_load,
   output logic [WIDTH*HEIGHT-1:0]   grid_load_data,
   output logic                      grid_step,
   output logic                      busy,
   output logic [GEN_W-1:0]          gen_count,
   output logic                      halt_valid,
   output logic [1:0]                halt_reason,
   output logic                      cmd_err
);

   localparam int N      = WIDTH * HEIGHT;
   localparam int PACE_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [PACE_W-1:0] PACE_MAX = PACE_W'(STEP_DIV - 1);
   localparam logic [PACE_W-1:0] PACE_ONE = PACE_W'(1);
   localparam logic [ROW_W:0]    ROW_LIM  = HEIGHT[ROW_W:0];

   state_e              state_r, state_s;
   logic                ret_run_r, ret_s;      // SETTLE returns to RUN when set, else IDLE
   logic [PACE_W-1:0]   pace_r, pace_s;
   logic [GEN_W-1:0]    gen_count_r, gen_s, gen_inc_s;
   halt_e               halt_reason_r, reason_s, hit_s;
   logic                load_s, step_s, halt_s, err_s, wr_en_s, clr_s;
   logic                grid_load_r, grid_step_r, halt_valid_r, cmd_err_r;
   logic                cmd_ready_r, busy_r;
   logic                accept_s, tick_s, row_ok_s;
   op_e                 op_s;

   assign op_s      = op_e'(cmd_op);
   assign accept_s  = cmd_valid & cmd_ready_r;
   assign tick_s    = (pace_r == PACE_MAX);
   assign row_ok_s  = ({1'b0, cmd_row} < ROW_LIM);
   assign gen_inc_s = (gen_count_r == {GEN_W{1'b1}}) ? gen_count_r
                                                     : gen_count_r + {{(GEN_W-1){1'b0}}, 1'b1};

   gol_shadow_buf #(
      .WIDTH  (WIDTH),
      .HEIGHT (HEIGHT),
      .ROW_W  (ROW_W)
   ) u_shadow (
      .clk     (clk),
      .rst     (rst),
      .clr     (clr_s),
      .wr_en   (wr_en_s),
      .wr_row  (cmd_row),
      .wr_data (cmd_data),
      .data    (grid_load_data)
   );

   // Halt check on the current array contents, in priority order
   always_comb begin
      if (grid_state == {N{1'b0}}) begin
         hit_s = H_EXTINCT;
      end else if (grid_next == grid_state) begin
         hit_s = H_STILL;
      end else if ((gen_limit != {GEN_W{1'b0}}) && (gen_count_r >= gen_limit)) begin
         hit_s = H_LIMIT;
      end else begin
         hit_s = H_NONE;
      end
   end

   // Next state, output pulses and bookkeeping for the command/pacing FSM
   always_comb begin
      state_s  = state_r;
      ret_s    = ret_run_r;
      pace_s   = pace_r;
      gen_s    = gen_count_r;
      reason_s = halt_reason_r;
      load_s   = 1'b0;
      step_s   = 1'b0;
      halt_s   = 1'b0;
      err_s    = 1'b0;
      wr_en_s  = 1'b0;
      clr_s    = 1'b0;
      case (state_r)
         S_IDLE, S_HALT: begin
            if (accept_s) begin
               case (op_s)
                  OP_WRITE_ROW: begin
                     if (row_ok_s) begin
                        wr_en_s = 1'b1;
                     end else begin
                        err_s = 1'b1;
                     end
                  end
                  OP_CLEAR: clr_s = 1'b1;
                  OP_COMMIT: begin
                     load_s   = 1'b1;
                     gen_s    = {GEN_W{1'b0}};
                     reason_s = H_NONE;
                     state_s  = S_IDLE;
                  end
                  OP_RUN: begin
                     state_s  = S_RUN;
                     pace_s   = {PACE_W{1'b0}};
                     reason_s = H_NONE;
                  end
                  OP_STEP: begin
                     if (hit_s != H_NONE) begin
                        state_s  = S_HALT;
                        halt_s   = 1'b1;
                        reason_s = hit_s;
                     end else begin
                        step_s   = 1'b1;
                        gen_s    = gen_inc_s;
                        reason_s = H_NONE;
                        state_s  = S_SETTLE;
                        ret_s    = 1'b0;
                     end
                  end
                  OP_NOP, OP_PAUSE: err_s = 1'b0;
                  default: err_s = 1'b1;
               endcase
            end else begin
               err_s = 1'b0;
            end
         end
         S_RUN: begin
            if (accept_s && (op_s == OP_PAUSE)) begin
               // Pause suppresses a pending step, but a halt found this cycle still wins
               if (tick_s && (hit_s != H_NONE)) begin
                  state_s  = S_HALT;
                  halt_s   = 1'b1;
                  reason_s = hit_s;
               end else begin
                  state_s = S_IDLE;
               end
               pace_s = {PACE_W{1'b0}};
            end else begin
               err_s = accept_s;
               if (tick_s) begin
                  pace_s = {PACE_W{1'b0}};
                  if (hit_s != H_NONE) begin
                     state_s  = S_HALT;
                     halt_s   = 1'b1;
                     reason_s = hit_s;
                  end else begin
                     step_s  = 1'b1;
                     gen_s   = gen_inc_s;
                     state_s = S_SETTLE;
                     ret_s   = 1'b1;
                  end
               end else begin
                  pace_s = pace_r + PACE_ONE;
               end
            end
         end
         S_SETTLE: begin
            state_s = ret_run_r ? S_RUN : S_IDLE;
            pace_s  = {PACE_W{1'b0}};
         end
         default: state_s = S_IDLE;
      endcase
   end

   // State and registered outputs; reset drops every pulse immediately
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r       <= S_IDLE;
         ret_run_r     <= 1'b0;
         pace_r        <= {PACE_W{1'b0}};
         gen_count_r   <= {GEN_W{1'b0}};
         halt_reason_r <= H_NONE;
         grid_load_r   <= 1'b0;
         grid_step_r   <= 1'b0;
         halt_valid_r  <= 1'b0;
         cmd_err_r     <= 1'b0;
         cmd_ready_r   <= 1'b0;
         busy_r        <= 1'b0;
      end else begin
         state_r       <= state_s;
         ret_run_r     <= ret_s;
         pace_r        <= pace_s;
         gen_count_r   <= gen_s;
         halt_reason_r <= reason_s;
         grid_load_r   <= load_s;
         grid_step_r   <= step_s;
         halt_valid_r  <= halt_s;
         cmd_err_r     <= err_s;
         cmd_ready_r   <= (state_s != S_SETTLE);
         busy_r        <= (state_s == S_RUN) || (state_s == S_SETTLE);
      end
   end

   assign cmd_ready   = cmd_ready_r;
   assign grid_load   = grid_load_r;
   assign grid_step   = grid_step_r;
   assign busy        = busy_r;
   assign gen_count   = gen_count_r;
   assign halt_valid  = halt_valid_r;
   assign halt_reason = halt_reason_r;
   assign cmd_err     = cmd_err_r;

endmodule
